// File: rtl/sched_queue_pkg.sv
// rtl/sched_queue_pkg.sv - shared widths, iop field positions and entry type for the scheduling queue
package sched_queue_pkg;

  localparam int IOP_W      = 32;
  localparam int IOP_INIT_W = 3;
  localparam int ENTRY_W    = IOP_W + IOP_INIT_W;

  localparam int SQ_DEPTH = 4;
  localparam int SQ_PTR_W = 2;

  localparam int IOP_AGU_HI = 30;
  localparam int IOP_AGU_LO = 24;
  localparam int IOP_ALU_HI = 23;
  localparam int IOP_ALU_LO = 5;
  localparam int IOP_MEM_HI = 4;
  localparam int IOP_MEM_LO = 3;

  localparam int INIT_ALU    = 2;
  localparam int INIT_DIRECT = 1;
  localparam int INIT_AGU    = 0;

  typedef struct packed {
    logic [IOP_W-1:0]      iop;
    logic [IOP_INIT_W-1:0] init;
  } sq_entry_t;

endpackage

// File: rtl/sched_queue_if.sv
// rtl/sched_queue_if.sv - decoder push, flush and execute-side head signals of the scheduling queue
interface sched_queue_if #(
  parameter int PTR_W = sched_queue_pkg::SQ_PTR_W
);
  logic                                  flush;
  logic                                  id_feed;
  logic [sched_queue_pkg::IOP_W-1:0]      id_iop;
  logic [sched_queue_pkg::IOP_INIT_W-1:0] id_iop_init;
  logic                                  q_hold;
  logic                                  sq_valid;
  logic [sched_queue_pkg::IOP_W-1:0]      sq_iop;
  logic [sched_queue_pkg::IOP_INIT_W-1:0] sq_init;
  logic                                  sq_pop;
  logic [PTR_W:0]                        sq_count;
  logic                                  sq_ovf;

  modport master (
    output flush, id_feed, id_iop, id_iop_init, sq_pop,
    input  q_hold, sq_valid, sq_iop, sq_init, sq_count, sq_ovf
  );

  modport slave (
    input  flush, id_feed, id_iop, id_iop_init, sq_pop,
    output q_hold, sq_valid, sq_iop, sq_init, sq_count, sq_ovf
  );
endinterface

// File: rtl/sched_queue_mem.sv
// rtl/sched_queue_mem.sv - reset-free entry array, one write port and one async read port
module sched_queue_mem #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 35
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sched_queue.sv
// rtl/sched_queue.sv - in-order scheduling queue between decode and execute, with decoder hold
// Optional SCHED_QUEUE_BYPASS_EN: empty-queue pushes appear at the head in the same cycle.
module sched_queue
  import sched_queue_pkg::*;
#(
  parameter int DEPTH = SQ_DEPTH,
  parameter int PTR_W = SQ_PTR_W
) (
  input  logic         clk,
  input  logic         a_rst,
  sched_queue_if.slave bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] LAST_CNT = (PTR_W+1)'(DEPTH - 1);

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;
  logic             q_hold_r, ovf_r;
  sq_entry_t        feed_entry, mem_rdata, head;
  logic             full, stored_valid, head_valid, bypass_hit, bypass_take;
  logic             push_ok, pop_ok, mem_we, advance_rd;

  assign full         = (count == FULL_CNT);
  assign stored_valid = (count != '0);
  assign feed_entry   = '{iop: bus.id_iop, init: bus.id_iop_init};

`ifdef SCHED_QUEUE_BYPASS_EN
  assign bypass_hit = ~stored_valid & bus.id_feed & ~bus.flush;
`else
  assign bypass_hit = 1'b0;
`endif

  assign head_valid  = stored_valid | bypass_hit;
  assign pop_ok      = bus.sq_pop & head_valid;
  assign push_ok     = bus.id_feed & (~full | pop_ok);
  // A bypassed op consumed in the same cycle never touches storage or pointers.
  assign bypass_take = bypass_hit & bus.sq_pop;
  assign mem_we      = push_ok & ~bypass_take;
  assign advance_rd  = pop_ok & ~bypass_take;

  sched_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (feed_entry),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (a_rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      q_hold_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (bus.flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      q_hold_r <= 1'b0;
    end else begin
      if (mem_we)     wr_ptr <= wr_ptr + 1'b1;
      if (advance_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({mem_we, advance_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      q_hold_r <= full | ((count == LAST_CNT) & push_ok & ~pop_ok);
      if (bus.id_feed & full & ~pop_ok) ovf_r <= 1'b1;
    end
  end

  // Head reads zero when empty so reset leaves the op/mask outputs clean.
  always_comb begin
    head = '0;
    if (bypass_hit)        head = feed_entry;
    else if (stored_valid) head = mem_rdata;
  end

  assign bus.sq_valid = head_valid;
  assign bus.sq_iop   = head.iop;
  assign bus.sq_init  = head.init;
  assign bus.sq_count = count;
  assign bus.q_hold   = q_hold_r;
  assign bus.sq_ovf   = ovf_r;

endmodule
